// File: rtl/tick_stopwatch_if.sv
// Control/display bundle between the timebase, the stopwatch and the display path.
// Optional lap input exists only when TICK_STOPWATCH_LAP_EN is defined.
`timescale 1ns/1ps
interface tick_stopwatch_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    tick;
  logic                    start_stop;
  logic                    clear;
`ifdef TICK_STOPWATCH_LAP_EN
  logic                    lap;
`endif
  logic [4*NUM_DIGITS-1:0] bcd;
  logic                    running;
  logic                    overflow;

`ifdef TICK_STOPWATCH_LAP_EN
  modport master (output tick, start_stop, clear, lap,
                  input  bcd, running, overflow);
  modport slave  (input  tick, start_stop, clear, lap,
                  output bcd, running, overflow);
`else
  modport master (output tick, start_stop, clear,
                  input  bcd, running, overflow);
  modport slave  (input  tick, start_stop, clear,
                  output bcd, running, overflow);
`endif
endinterface

// File: rtl/tick_stopwatch.sv
// Multi-digit BCD stopwatch advanced by timebase ticks, with start/stop and clear.
// Define TICK_STOPWATCH_LAP_EN to add the lap-hold display feature.
`timescale 1ns/1ps
module tick_stopwatch #(
  parameter int NUM_DIGITS = 4,
  parameter bit ROLLOVER   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  tick_stopwatch_if.slave    bus
);

  localparam int W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [W-1:0]   count;
  logic [W-1:0]   count_nx;
  logic [W-1:0]   count_inc;
  logic [W-1:0]   bcd_q;
  logic [W-1:0]   bcd_nx;
  logic           running_q;
  logic           overflow_q;
  logic           overflow_nx;
  logic           carry;
  logic           at_max;
  logic           inc_en;

`ifdef TICK_STOPWATCH_LAP_EN
  logic [W-1:0]   lap_q;
  logic [W-1:0]   lap_nx;
  logic           lap_hold;
  logic           lap_hold_nx;
`endif

  // Decimal ripple: a 9 wraps to 0 and passes the carry on; a carry out of the
  // top digit means every digit was 9.
  always_comb begin
    count_inc = count;
    carry     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] >= 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    at_max = carry;
  end

  assign inc_en = (state == RUN) && bus.tick && !bus.clear;

  always_comb begin
    state_nx    = state;
    count_nx    = count;
    overflow_nx = ROLLOVER ? 1'b0 : overflow_q;
`ifdef TICK_STOPWATCH_LAP_EN
    lap_nx      = lap_q;
    lap_hold_nx = lap_hold;
`endif

    if (bus.clear) begin
      state_nx    = IDLE;
      count_nx    = '0;
      overflow_nx = 1'b0;
`ifdef TICK_STOPWATCH_LAP_EN
      lap_nx      = '0;
      lap_hold_nx = 1'b0;
`endif
    end else begin
      if (inc_en) begin
        if (at_max) begin
          overflow_nx = 1'b1;
          count_nx    = ROLLOVER ? '0 : count;
        end else begin
          count_nx    = count_inc;
        end
      end

`ifdef TICK_STOPWATCH_LAP_EN
      // Lap captures the pre-increment count so a coincident tick is not shown.
      if ((state == RUN) && bus.lap) begin
        if (lap_hold) begin
          lap_hold_nx = 1'b0;
        end else begin
          lap_hold_nx = 1'b1;
          lap_nx      = count;
        end
      end
`endif

      if (bus.start_stop) begin
        unique case (state)
          IDLE:    state_nx = RUN;
          RUN:     state_nx = PAUSE;
          PAUSE:   state_nx = RUN;
          default: state_nx = IDLE;
        endcase
      end
    end

`ifdef TICK_STOPWATCH_LAP_EN
    bcd_nx = lap_hold_nx ? lap_nx : count_nx;
`else
    bcd_nx = count_nx;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      bcd_q      <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
`ifdef TICK_STOPWATCH_LAP_EN
      lap_q      <= '0;
      lap_hold   <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      count      <= count_nx;
      bcd_q      <= bcd_nx;
      running_q  <= (state_nx == RUN);
      overflow_q <= overflow_nx;
`ifdef TICK_STOPWATCH_LAP_EN
      lap_q      <= lap_nx;
      lap_hold   <= lap_hold_nx;
`endif
    end
  end

  assign bus.bcd      = bcd_q;
  assign bus.running  = running_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_tick_stopwatch.sv
// Bench for tick_stopwatch: a wrapping and a saturating instance driven in parallel,
// checked every cycle against an integer-count model plus literal expectations.
`timescale 1ns/1ps
module tb_tick_stopwatch;

  localparam int ND     = 4;
  localparam int W      = 4 * ND;
  localparam int MAXV   = 9999;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PAUSE = 2;

  logic clk        = 1'b0;
  logic rst_n      = 1'b1;
  logic tick       = 1'b0;
  logic start_stop = 1'b0;
  logic clear      = 1'b0;
  logic lap        = 1'b0;

  int n_compared = 0;
  int n_failed   = 0;

  int m_mode    [2];
  int m_n       [2];
  int m_lap_val [2];
  bit m_ovf     [2];
  bit m_hold    [2];

  always #5 clk = ~clk;

  tick_stopwatch_if #(.NUM_DIGITS(ND)) bus_roll ();
  tick_stopwatch_if #(.NUM_DIGITS(ND)) bus_sat ();

  assign bus_roll.tick       = tick;
  assign bus_roll.start_stop = start_stop;
  assign bus_roll.clear      = clear;
  assign bus_sat.tick        = tick;
  assign bus_sat.start_stop  = start_stop;
  assign bus_sat.clear       = clear;
`ifdef TICK_STOPWATCH_LAP_EN
  assign bus_roll.lap        = lap;
  assign bus_sat.lap         = lap;
`endif

  tick_stopwatch #(.NUM_DIGITS(ND), .ROLLOVER(1'b1)) dut_roll (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_roll)
  );

  tick_stopwatch #(.NUM_DIGITS(ND), .ROLLOVER(1'b0)) dut_sat (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_sat)
  );

  function automatic logic [W-1:0] to_bcd(input int v);
    int p;
    p      = 1;
    to_bcd = '0;
    for (int i = 0; i < ND; i++) begin
      to_bcd[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
  endfunction

  // Model: plain integer count, digits derived by division only for display.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = M_IDLE; m_n[k] = 0; m_lap_val[k] = 0; m_ovf[k] = 0; m_hold[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int old;
        old = m_n[k];
        if (clear) begin
          m_mode[k] = M_IDLE; m_n[k] = 0; m_lap_val[k] = 0; m_ovf[k] = 0; m_hold[k] = 0;
        end else begin
          if (k == 0) m_ovf[k] = 0;
          if (m_mode[k] == M_RUN && tick) begin
            if (old == MAXV) begin
              m_ovf[k] = 1;
              if (k == 0) m_n[k] = 0;
            end else begin
              m_n[k] = old + 1;
            end
          end
`ifdef TICK_STOPWATCH_LAP_EN
          if (m_mode[k] == M_RUN && lap) begin
            if (m_hold[k]) m_hold[k] = 0;
            else begin
              m_hold[k] = 1;
              m_lap_val[k] = old;
            end
          end
`endif
          if (start_stop) m_mode[k] = (m_mode[k] == M_RUN) ? M_PAUSE : M_RUN;
        end
      end
    end
  end

  task automatic check_output(input string name,
                              input logic [W-1:0] act_bcd, input logic act_run, input logic act_ovf,
                              input logic [W-1:0] exp_bcd, input logic exp_run, input logic exp_ovf);
    n_compared++;
    if (act_bcd !== exp_bcd || act_run !== exp_run || act_ovf !== exp_ovf) begin
      n_failed++;
      $display("[TB] FAIL %s at %0t: got bcd=%h running=%b overflow=%b, expected bcd=%h running=%b overflow=%b",
               name, $time, act_bcd, act_run, act_ovf, exp_bcd, exp_run, exp_ovf);
    end
  endtask

  task automatic check_dut(input string name, input int k,
                           input logic [W-1:0] exp_bcd, input logic exp_run, input logic exp_ovf);
    if (k == 0)
      check_output({name, "/roll"}, bus_roll.bcd, bus_roll.running, bus_roll.overflow,
                   exp_bcd, exp_run, exp_ovf);
    else
      check_output({name, "/sat"}, bus_sat.bcd, bus_sat.running, bus_sat.overflow,
                   exp_bcd, exp_run, exp_ovf);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [W-1:0] eb;
      eb = to_bcd(m_hold[k] ? m_lap_val[k] : m_n[k]);
      check_dut("model", k, eb, m_mode[k] == M_RUN, m_ovf[k]);
    end
  end

  task automatic apply_stimulus(input bit t, input bit s, input bit c, input bit l);
    tick = t; start_stop = s; clear = c; lap = l;
    @(negedge clk);
    tick = 0; start_stop = 0; clear = 0; lap = 0;
  endtask

  task automatic run_ticks(input int n);
    repeat (n) apply_stimulus(1, 0, 0, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_dut("reset", 0, 16'h0000, 0, 0);
    check_dut("reset", 1, 16'h0000, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    apply_stimulus(0, 1, 0, 0);
    check_dut("start", 0, 16'h0000, 1, 0);
    run_ticks(1);
    check_dut("first_tick", 0, 16'h0001, 1, 0);
    run_ticks(11);
    check_dut("twelve", 0, 16'h0012, 1, 0);
    run_ticks(87);
    check_dut("at_99", 0, 16'h0099, 1, 0);
    run_ticks(1);
    check_dut("ripple_100", 0, 16'h0100, 1, 0);
    check_dut("ripple_100", 1, 16'h0100, 1, 0);

    apply_stimulus(0, 0, 1, 0);
    check_dut("clear_run", 0, 16'h0000, 0, 0);
    apply_stimulus(0, 1, 0, 0);
    run_ticks(5);
    check_dut("at_5", 0, 16'h0005, 1, 0);
    apply_stimulus(1, 1, 0, 0);
    check_dut("tick_stop_run", 0, 16'h0006, 0, 0);
    apply_stimulus(1, 0, 0, 0);
    check_dut("tick_in_pause", 0, 16'h0006, 0, 0);
    apply_stimulus(1, 1, 0, 0);
    check_dut("tick_start_pause", 0, 16'h0006, 1, 0);
    apply_stimulus(1, 1, 1, 0);
    check_dut("clear_all", 0, 16'h0000, 0, 0);
    apply_stimulus(0, 0, 1, 0);
    check_dut("clear_idle", 0, 16'h0000, 0, 0);
    apply_stimulus(1, 0, 0, 0);
    check_dut("tick_in_idle", 0, 16'h0000, 0, 0);

    apply_stimulus(0, 1, 0, 0);
    run_ticks(MAXV);
    check_dut("at_max", 0, 16'h9999, 1, 0);
    check_dut("at_max", 1, 16'h9999, 1, 0);
    run_ticks(1);
    check_dut("wrap", 0, 16'h0000, 1, 1);
    check_dut("saturate", 1, 16'h9999, 1, 1);
    apply_stimulus(0, 0, 0, 0);
    check_dut("ovf_pulse_end", 0, 16'h0000, 1, 0);
    check_dut("ovf_sticky", 1, 16'h9999, 1, 1);
    run_ticks(2);
    check_dut("after_wrap", 0, 16'h0002, 1, 0);
    check_dut("sat_hold", 1, 16'h9999, 1, 1);
    apply_stimulus(0, 0, 1, 0);
    check_dut("clear_ovf", 0, 16'h0000, 0, 0);
    check_dut("clear_ovf", 1, 16'h0000, 0, 0);

`ifdef TICK_STOPWATCH_LAP_EN
    apply_stimulus(0, 1, 0, 0);
    run_ticks(20);
    apply_stimulus(0, 0, 0, 1);
    check_dut("lap_latch", 0, 16'h0020, 1, 0);
    run_ticks(5);
    check_dut("lap_hold", 0, 16'h0020, 1, 0);
    apply_stimulus(0, 0, 0, 1);
    check_dut("lap_release", 0, 16'h0025, 1, 0);
    apply_stimulus(1, 0, 0, 1);
    check_dut("lap_with_tick", 0, 16'h0025, 1, 0);
    apply_stimulus(0, 0, 0, 1);
    check_dut("lap_release2", 0, 16'h0026, 1, 0);
    apply_stimulus(0, 0, 1, 0);
`endif

    apply_stimulus(0, 1, 0, 0);
    run_ticks(347);
    check_dut("at_347", 0, 16'h0347, 1, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_dut("async_reset", 0, 16'h0000, 0, 0);
    check_dut("async_reset", 1, 16'h0000, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_dut("post_reset", 0, 16'h0000, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/tick_stopwatch.md
Name: tick_stopwatch

Overview:
- Downstream consumer of the tick from the 20-bit counter/comparator timebase.
- Uses each single-cycle tick as a count enable for a multi-digit BCD stopwatch with start/stop and clear control.
- Output feeds the 7-segment display path as packed BCD digits plus status flags.

Parameters:
- NUM_DIGITS, 4, number of BCD digits; count range 0 to 10^NUM_DIGITS-1.
- ROLLOVER, 1, 1 = wrap to zero at max; 0 = saturate at max.

Ports:
- clk  input  1  system clock; same clock as the tick generator.
- rst  input  1  asynchronous, active-low reset.
- tick  input  1  single-cycle count enable from the timebase comparator.
- start_stop  input  1  single-cycle pulse; toggles run/pause.
- clear  input  1  single-cycle pulse; zeroes the count and returns to IDLE.
- bcd  output  4*NUM_DIGITS  packed BCD value; digit 0 is in bits [3:0].
- running  output  1  high while in RUN.
- overflow  output  1  max-count event flag (see Behaviour).

Behaviour:
- Reset: rst low asynchronously forces state=IDLE, count=0, bcd=0, running=0, overflow=0. Deassertion is synchronous to clk via the existing reset handling.
- States:
  - IDLE: count=0.
  - RUN: counting.
  - PAUSE: count held.
- Transitions, evaluated on each rising clk edge:
  - IDLE: start_stop -> RUN.
  - RUN: start_stop -> PAUSE; clear -> IDLE.
  - PAUSE: start_stop -> RUN; clear -> IDLE.
  - clear in IDLE: stays in IDLE; no effect.
- Priority: clear > start_stop > tick.
  - clear together with start_stop or tick: IDLE, count=0, no increment.
- Increment: in RUN, a tick high at an edge advances the count by 1 at that edge. bcd shows the new value one cycle later; it is a registered output, with no combinational path from tick.
  - The increment uses the current (registered) state. tick+start_stop in RUN: increment applies and state goes to PAUSE. tick+start_stop in IDLE/PAUSE: no increment; state goes to RUN.
- BCD arithmetic:
  - Each digit counts 0..9.
  - Digit at 9 on increment -> 0 with carry into the next digit, rippling within the same cycle.
  - Digits never hold 0xA-0xF.
- Max count = all digits 9:
  - ROLLOVER=1: next tick -> all zeros, stays in RUN, overflow high for exactly one clk cycle.
  - ROLLOVER=0: count holds at max, stays in RUN, overflow goes high and stays high (sticky) until clear or reset. Further ticks have no effect.
- running = (state==RUN), registered.
- Ticks arriving in IDLE or PAUSE are ignored and are not queued.
- Reset mid-count: immediate zero, no partial digit update visible.

Optional Feature:
- Macro: TICK_STOPWATCH_LAP_EN.
- Defined:
  - Adds input port lap (1-bit single-cycle pulse) and an internal lap register of width 4*NUM_DIGITS.
  - In RUN, a lap pulse latches the live count into the lap register and sets lap_hold. While lap_hold=1, bcd shows the lap register and the live count keeps advancing.
  - A second lap pulse clears lap_hold; bcd returns to the live count next cycle.
  - lap and tick on the same edge: the pre-increment count is latched.
  - clear or reset clears lap_hold and the lap register.
  - lap in IDLE/PAUSE is ignored.
- Undefined: no lap port; bcd always equals the live count.

Test Plan:
- Reset, then start_stop, then 12 ticks -> running=1, bcd=0x0012; bcd updates one cycle after each tick.
- Count to 0x0099, then 1 tick -> bcd=0x0100 (two-digit carry ripple); no digit ever reads above 9.
- ROLLOVER=1: preload via 9999 ticks to 0x9999, then 1 tick -> bcd=0x0000, overflow high for 1 cycle, running=1.
- ROLLOVER=0: at 0x9999, then 3 ticks -> bcd=0x9999, overflow=1 sticky; clear -> bcd=0, overflow=0, IDLE.
- Same-edge events:
  - RUN at 0x0005, tick+start_stop together -> bcd=0x0006, running=0.
  - PAUSE, tick+start_stop together -> bcd unchanged, running=1.
  - clear+tick+start_stop together -> bcd=0, running=0.
- rst pulled low asynchronously mid-RUN at 0x0347, between clock edges -> outputs zero immediately. With TICK_STOPWATCH_LAP_EN: lap at 0x0020, then 5 ticks -> bcd=0x0020; lap again -> bcd=0x0025.
